// File: rtl/decode_stage.sv
// decode_stage: RV32I ID stage. Decodes the IF beat and registers it into the ID/EX register.
// Latency: 1 cycle from an accepted IF beat to id_valid.
// Backpressure: if_ready drops on ~ex_ready or a load-use hazard; flush forces if_ready=1 and discards the beat.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   if_valid/if_instr/if_pc   instruction beat from IF
//   if_ready                  ID accepts the IF beat this cycle (combinational)
//   flush                     kill the ID/EX register contents and any incoming beat
//   ex_ready                  EX consumes the ID/EX register this cycle
//   id_valid/id_ctrl/id_pc    ID/EX register: valid, packed control bundle, PC
//   id_rs1/id_rs2/id_rd       register indices (zero when the instruction does not use them)
//   id_illegal                only with DECODE_ILLEGAL_FLAG_EN: held beat was an illegal instruction
//
// Optional feature macro: DECODE_ILLEGAL_FLAG_EN
//   defined   -> illegal beats are registered as valid entries flagged by id_illegal
//   undefined -> illegal beats are consumed and turned into bubbles

package coreUtils;

  // ALU operation codes: {funct7[5], funct3} for the RV32I ALU ops, plus a NOP.
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_NOP  = 4'b1111;

  typedef enum logic [1:0] {
    NON_TYPE         = 2'd0,
    JAL_TYPE         = 2'd1,
    JALR_TYPE        = 2'd2,
    CONDITIONAL_TYPE = 2'd3
  } branch_type_t;

  // 49-bit control bundle carried through the ID/EX register.
  typedef struct packed {
    logic [3:0]   alu_codes;
    branch_type_t branch_type;
    logic         isLoad;
    logic         Wmem;
    logic         Rmem;
    logic         Wreg;
    logic         aluIn1_m;   // rs1 is read
    logic         aluIn2_m;   // rs2 is read
    logic         aluImm_m;   // ALU operand B = imm
    logic         aluPC_m;    // ALU operand A = PC
    logic [2:0]   f3;
    logic [31:0]  imm;
  } control_signals_t;

  // Bubble: no architectural side effects, EX can use it without looking at id_valid.
  localparam control_signals_t BUBBLE_CTRL = '{
    alu_codes:   ALU_NOP,
    branch_type: NON_TYPE,
    isLoad:      1'b0,
    Wmem:        1'b0,
    Rmem:        1'b0,
    Wreg:        1'b0,
    aluIn1_m:    1'b0,
    aluIn2_m:    1'b0,
    aluImm_m:    1'b0,
    aluPC_m:     1'b0,
    f3:          3'b000,
    imm:         32'h0000_0000
  };

  // Immediate extractors. Argument v is instr[31:7], so instr[k] == v[k-7].
  function automatic logic [31:0] get_i_imm(input logic [24:0] v);
    return {{20{v[24]}}, v[24:13]};
  endfunction

  function automatic logic [31:0] get_s_imm(input logic [24:0] v);
    return {{20{v[24]}}, v[24:18], v[4:0]};
  endfunction

  function automatic logic [31:0] get_b_imm(input logic [24:0] v);
    return {{19{v[24]}}, v[24], v[0], v[23:18], v[4:1], 1'b0};
  endfunction

  function automatic logic [31:0] get_u_imm(input logic [24:0] v);
    return {v[24:5], 12'h000};
  endfunction

  function automatic logic [31:0] get_j_imm(input logic [24:0] v);
    return {{11{v[24]}}, v[24], v[12:5], v[13], v[23:14], 1'b0};
  endfunction

endpackage

module decode_stage
  import coreUtils::*;
#(
  parameter int                XLEN     = 32,   // only 32 is supported
  parameter logic [XLEN-1:0]   RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_ready,
  input  logic            flush,
  input  logic            ex_ready,
`ifdef DECODE_ILLEGAL_FLAG_EN
  output logic            id_illegal,
`endif
  output logic            id_valid,
  output logic [48:0]     id_ctrl,
  output logic [XLEN-1:0] id_pc,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic [4:0]      id_rd
);

  // Major opcodes, instr[6:2].
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  // ---------------------------------------------------------------------------
  // ID/EX register state
  // ---------------------------------------------------------------------------
  logic             valid_q, valid_d;
  control_signals_t ctrl_q,  ctrl_d;
  logic [XLEN-1:0]  pc_q,    pc_d;
  logic [4:0]       rs1_q,   rs1_d;
  logic [4:0]       rs2_q,   rs2_d;
  logic [4:0]       rd_q,    rd_d;
`ifdef DECODE_ILLEGAL_FLAG_EN
  logic             illegal_q, illegal_d;
`endif

  // ---------------------------------------------------------------------------
  // Combinational decode of the IF beat
  // ---------------------------------------------------------------------------
  control_signals_t dec;
  logic             dec_legal;
  logic [4:0]       dec_rs1, dec_rs2, dec_rd;
  logic [4:0]       opcode;
  logic [2:0]       f3;
  logic [24:0]      ibits;

  assign opcode = if_instr[6:2];
  assign f3     = if_instr[14:12];
  assign ibits  = if_instr[31:7];

  always_comb begin
    dec       = BUBBLE_CTRL;
    dec_legal = 1'b1;

    case (opcode)
      OPC_LUI: begin
        dec.Wreg      = 1'b1;
        dec.aluImm_m  = 1'b1;
        dec.imm       = get_u_imm(ibits);
        dec.alu_codes = ALU_ADD;
      end
      OPC_AUIPC: begin
        dec.Wreg      = 1'b1;
        dec.aluPC_m   = 1'b1;
        dec.aluImm_m  = 1'b1;
        dec.imm       = get_u_imm(ibits);
        dec.alu_codes = ALU_ADD;
      end
      OPC_OPIMM: begin
        dec.Wreg      = 1'b1;
        dec.aluIn1_m  = 1'b1;
        dec.aluImm_m  = 1'b1;
        dec.imm       = get_i_imm(ibits);
        // instr[30] selects SRAI only; for the other OP-IMM ops it is immediate data.
        dec.alu_codes = {if_instr[30] & (f3 == 3'b101), f3};
      end
      OPC_OP: begin
        dec.Wreg      = 1'b1;
        dec.aluIn1_m  = 1'b1;
        dec.aluIn2_m  = 1'b1;
        dec.alu_codes = {if_instr[30], f3};
      end
      OPC_LOAD: begin
        dec.Wreg      = 1'b1;
        dec.Rmem      = 1'b1;
        dec.isLoad    = 1'b1;
        dec.aluIn1_m  = 1'b1;
        dec.aluImm_m  = 1'b1;
        dec.imm       = get_i_imm(ibits);
        dec.alu_codes = ALU_ADD;
      end
      OPC_STORE: begin
        dec.Wmem      = 1'b1;
        dec.aluIn1_m  = 1'b1;
        dec.aluIn2_m  = 1'b1;
        dec.aluImm_m  = 1'b1;
        dec.imm       = get_s_imm(ibits);
        dec.alu_codes = ALU_ADD;
      end
      OPC_JAL: begin
        dec.Wreg        = 1'b1;
        dec.aluPC_m     = 1'b1;
        dec.imm         = get_j_imm(ibits);
        dec.branch_type = JAL_TYPE;
        dec.alu_codes   = ALU_ADD;
      end
      OPC_JALR: begin
        dec.Wreg        = 1'b1;
        dec.aluIn1_m    = 1'b1;
        dec.aluImm_m    = 1'b1;
        dec.imm         = get_i_imm(ibits);
        dec.branch_type = JALR_TYPE;
        dec.alu_codes   = ALU_ADD;
      end
      OPC_BRANCH: begin
        dec.aluIn1_m    = 1'b1;
        dec.aluIn2_m    = 1'b1;
        dec.imm         = get_b_imm(ibits);
        dec.branch_type = CONDITIONAL_TYPE;
        dec.alu_codes   = ALU_SUB;
      end
      default: dec_legal = 1'b0;
    endcase

    // Compressed / reserved encodings are not supported.
    if (if_instr[1:0] != 2'b11) dec_legal = 1'b0;

    if (dec_legal) dec.f3 = f3;
    else           dec    = BUBBLE_CTRL;

    // Indices the instruction does not use are zeroed so the hazard compare
    // and the register file never see stale encoding bits.
    dec_rs1 = dec.aluIn1_m ? if_instr[19:15] : 5'd0;
    dec_rs2 = dec.aluIn2_m ? if_instr[24:20] : 5'd0;
    dec_rd  = dec.Wreg     ? if_instr[11:7]  : 5'd0;
  end

  // ---------------------------------------------------------------------------
  // Load-use hazard: the load in ID/EX has not produced data yet, so a consumer
  // of its rd must wait one cycle. x0 never carries a dependency.
  // ---------------------------------------------------------------------------
  logic hazard;
  logic rs1_match, rs2_match;

  assign rs1_match = dec.aluIn1_m & (dec_rs1 == rd_q);
  assign rs2_match = dec.aluIn2_m & (dec_rs2 == rd_q);
  assign hazard    = valid_q & ctrl_q.isLoad & (rd_q != 5'd0) &
                     (rs1_match | rs2_match) & if_valid;

  // During flush the beat is taken off IF's hands and dropped.
  assign if_ready = (ex_ready & ~hazard) | flush;

  // ---------------------------------------------------------------------------
  // ID/EX next state, highest priority first
  // ---------------------------------------------------------------------------
  always_comb begin
    valid_d   = valid_q;
    ctrl_d    = ctrl_q;
    pc_d      = pc_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
`ifdef DECODE_ILLEGAL_FLAG_EN
    illegal_d = illegal_q;
`endif

    if (flush || (ex_ready && (hazard || !if_valid))) begin
      // Bubble: flush (independent of ex_ready), hazard stall, or nothing offered.
      valid_d   = 1'b0;
      ctrl_d    = BUBBLE_CTRL;
      rs1_d     = 5'd0;
      rs2_d     = 5'd0;
      rd_d      = 5'd0;
`ifdef DECODE_ILLEGAL_FLAG_EN
      illegal_d = 1'b0;
`endif
    end else if (ex_ready) begin
      // if_valid is set and there is no hazard here.
      if (dec_legal) begin
        valid_d   = 1'b1;
        ctrl_d    = dec;
        pc_d      = if_pc;
        rs1_d     = dec_rs1;
        rs2_d     = dec_rs2;
        rd_d      = dec_rd;
`ifdef DECODE_ILLEGAL_FLAG_EN
        illegal_d = 1'b0;
`endif
      end else begin
`ifdef DECODE_ILLEGAL_FLAG_EN
        // Keep the faulting PC visible to a downstream trap unit; the control
        // bundle stays a bubble so nothing architectural happens in EX.
        valid_d   = 1'b1;
        illegal_d = 1'b1;
        pc_d      = if_pc;
`else
        valid_d   = 1'b0;
`endif
        ctrl_d    = BUBBLE_CTRL;
        rs1_d     = 5'd0;
        rs2_d     = 5'd0;
        rd_d      = 5'd0;
      end
    end
    // else: ~ex_ready without flush -> hold everything
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      ctrl_q    <= BUBBLE_CTRL;
      pc_q      <= RESET_PC;
      rs1_q     <= 5'd0;
      rs2_q     <= 5'd0;
      rd_q      <= 5'd0;
`ifdef DECODE_ILLEGAL_FLAG_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      pc_q      <= pc_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
`ifdef DECODE_ILLEGAL_FLAG_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  assign id_valid   = valid_q;
  assign id_ctrl    = ctrl_q;
  assign id_pc      = pc_q;
  assign id_rs1     = rs1_q;
  assign id_rs2     = rs2_q;
  assign id_rd      = rd_q;
`ifdef DECODE_ILLEGAL_FLAG_EN
  assign id_illegal = illegal_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed bench for decode_stage with an expected-output queue.
// Expected ID/EX contents are queued when a beat is expected to be accepted and
// compared when the register is presented to EX (id_valid & ex_ready).
module tb_decode_stage;

  localparam logic [31:0] RPC = 32'h0000_0100;

  // Control bundle layout: {alu[3:0], btype[1:0], flags[7:0], f3[2:0], imm[31:0]}
  // flags = {isLoad, Wmem, Rmem, Wreg, in1, in2, aluImm, aluPC}
  localparam logic [48:0] BUBBLE = {4'b1111, 2'd0, 8'h00, 3'b000, 32'h0};

  typedef struct {
    logic [48:0] ctrl;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, if_valid, flush, ex_ready;
  logic [31:0] if_instr, if_pc;
  logic        if_ready, id_valid;
  logic [48:0] id_ctrl;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1, id_rs2, id_rd;
`ifdef DECODE_ILLEGAL_FLAG_EN
  logic        id_illegal;
`endif

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .RESET_PC(RPC)) dut (
`ifdef DECODE_ILLEGAL_FLAG_EN
    .id_illegal(id_illegal),
`endif
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
    .flush(flush), .ex_ready(ex_ready),
    .id_valid(id_valid), .id_ctrl(id_ctrl), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd)
  );

  function automatic logic [48:0] mk(input logic [3:0] alu, input logic [1:0] bt,
                                     input logic [7:0] fl, input logic [2:0] f3,
                                     input logic [31:0] imm);
    return {alu, bt, fl, f3, imm};
  endfunction

  function automatic exp_t mkexp(input logic [48:0] c, input logic [4:0] r1,
                                 input logic [4:0] r2, input logic [4:0] rd,
                                 input logic [31:0] pc, input logic ill);
    exp_t e;
    e.ctrl = c; e.rs1 = r1; e.rs2 = r2; e.rd = rd; e.pc = pc; e.ill = ill;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [48:0] got, input logic [48:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // One clock: check if_ready and the presented ID/EX entry mid-cycle, then
  // let the edge happen and return #1 after it.
  task automatic tick(input logic exp_rdy);
    exp_t e;
    @(negedge clk);
    chk("if_ready", if_ready, exp_rdy);
    if (id_valid && flush) begin
      if (sb.size() > 0) e = sb.pop_front();   // killed by flush
    end else if (id_valid && ex_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_out: got pc %h want no output", id_pc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("ctrl", id_ctrl, e.ctrl);
        chk("pc",   id_pc,   e.pc);
        chk("rs1",  id_rs1,  e.rs1);
        chk("rs2",  id_rs2,  e.rs2);
        chk("rd",   id_rd,   e.rd);
`ifdef DECODE_ILLEGAL_FLAG_EN
        chk("illegal", id_illegal, e.ill);
`endif
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] ins, input logic [31:0] pc,
                      input logic exp_rdy, input logic do_push, input exp_t e);
    if_valid = 1'b1;
    if_instr = ins;
    if_pc    = pc;
    if (do_push) sb.push_back(e);
    tick(exp_rdy);
  endtask

  task automatic idle(input logic exp_rdy);
    if_valid = 1'b0;
    if_instr = 32'h0;
    tick(exp_rdy);
  endtask

  // Expected bundles for the instructions used below.
  localparam logic [48:0] ADDI5_C = mk(4'b0000, 2'd0, 8'b0001_1010, 3'b000, 32'd5);
  localparam logic [48:0] SUB_C   = mk(4'b1000, 2'd0, 8'b0001_1100, 3'b000, 32'd0);
  localparam logic [48:0] SRAI_C  = mk(4'b1101, 2'd0, 8'b0001_1010, 3'b101, 32'h403);
  localparam logic [48:0] BEQ_C   = mk(4'b1000, 2'd3, 8'b0000_1100, 3'b000, 32'hFFFF_FFF8);
  localparam logic [48:0] JAL_C   = mk(4'b0000, 2'd1, 8'b0001_0001, 3'b000, 32'h800);
  localparam logic [48:0] LW_C    = mk(4'b0000, 2'd0, 8'b1011_1010, 3'b010, 32'd0);
  localparam logic [48:0] ADD_C   = mk(4'b0000, 2'd0, 8'b0001_1100, 3'b000, 32'd0);

  exp_t none;

  initial begin
    none     = mkexp(BUBBLE, 0, 0, 0, 0, 0);
    rst      = 1'b1;
    if_valid = 1'b0;
    if_instr = 32'h0;
    if_pc    = 32'h0;
    flush    = 1'b0;
    ex_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_valid", id_valid, 1'b0);
    chk("rst_alu",   id_ctrl[48:45], 4'b1111);
    chk("rst_ctrl",  id_ctrl, BUBBLE);
    chk("rst_pc",    id_pc, RPC);
    chk("rst_rd",    id_rd, 5'd0);

    // addi x1,x0,5: one-cycle latency
    beat(32'h0050_0093, 32'h100, 1'b1, 1'b1, mkexp(ADDI5_C, 5'd0, 5'd0, 5'd1, 32'h100, 1'b0));
    if_valid = 1'b0;
    chk("addi_latency", id_valid, 1'b1);
    idle(1'b1);

    // Decode sweep, back-to-back
    beat(32'h4020_81B3, 32'h104, 1'b1, 1'b1, mkexp(SUB_C,  5'd1, 5'd2, 5'd3, 32'h104, 1'b0));
    beat(32'h4032_D293, 32'h108, 1'b1, 1'b1, mkexp(SRAI_C, 5'd5, 5'd0, 5'd5, 32'h108, 1'b0));
    beat(32'hFE20_8CE3, 32'h10C, 1'b1, 1'b1, mkexp(BEQ_C,  5'd1, 5'd2, 5'd0, 32'h10C, 1'b0));
    beat(32'h0010_00EF, 32'h110, 1'b1, 1'b1, mkexp(JAL_C,  5'd0, 5'd0, 5'd1, 32'h110, 1'b0));
    idle(1'b1);

    // Load-use: lw x5,0(x6) then add x7,x5,x1 stalls one cycle
    beat(32'h0003_2283, 32'h200, 1'b1, 1'b1, mkexp(LW_C, 5'd6, 5'd0, 5'd5, 32'h200, 1'b0));
    beat(32'h0012_83B3, 32'h204, 1'b0, 1'b0, none);
    chk("lu_bubble_valid", id_valid, 1'b0);
    chk("lu_bubble_ctrl",  id_ctrl, BUBBLE);
    beat(32'h0012_83B3, 32'h204, 1'b1, 1'b1, mkexp(ADD_C, 5'd5, 5'd1, 5'd7, 32'h204, 1'b0));
    // lw x0 followed by add x7,x0,x1: no stall
    beat(32'h0003_2003, 32'h208, 1'b1, 1'b1, mkexp(LW_C, 5'd6, 5'd0, 5'd0, 32'h208, 1'b0));
    beat(32'h0010_03B3, 32'h20C, 1'b1, 1'b1, mkexp(ADD_C, 5'd0, 5'd1, 5'd7, 32'h20C, 1'b0));
    idle(1'b1);

    // Back-pressure: hold for 3 cycles
    beat(32'h4020_81B3, 32'h300, 1'b1, 1'b1, mkexp(SUB_C, 5'd1, 5'd2, 5'd3, 32'h300, 1'b0));
    ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat(32'h0050_0093, 32'h304, 1'b0, 1'b0, none);
      chk("hold_valid", id_valid, 1'b1);
      chk("hold_pc",    id_pc, 32'h300);
      chk("hold_ctrl",  id_ctrl, SUB_C);
      chk("hold_rd",    id_rd, 5'd3);
    end
    ex_ready = 1'b1;
    beat(32'h0050_0093, 32'h304, 1'b1, 1'b1, mkexp(ADDI5_C, 5'd0, 5'd0, 5'd1, 32'h304, 1'b0));
    idle(1'b1);

    // Flush while ex_ready=0 and a load-use hazard is present
    beat(32'h0003_2283, 32'h400, 1'b1, 1'b1, mkexp(LW_C, 5'd6, 5'd0, 5'd5, 32'h400, 1'b0));
    ex_ready = 1'b0;
    flush    = 1'b1;
    beat(32'h0012_83B3, 32'h404, 1'b1, 1'b0, none);
    flush    = 1'b0;
    ex_ready = 1'b1;
    if_valid = 1'b0;
    chk("flush_valid", id_valid, 1'b0);
    chk("flush_ctrl",  id_ctrl, BUBBLE);
    idle(1'b1);

    // Illegal beats: unknown opcode, then a valid opcode with instr[1:0]!=2'b11
`ifdef DECODE_ILLEGAL_FLAG_EN
    beat(32'h0000_007F, 32'h500, 1'b1, 1'b1, mkexp(BUBBLE, 5'd0, 5'd0, 5'd0, 32'h500, 1'b1));
    chk("ill_valid", id_valid, 1'b1);
    chk("ill_flag",  id_illegal, 1'b1);
    beat(32'h0050_0090, 32'h504, 1'b1, 1'b1, mkexp(BUBBLE, 5'd0, 5'd0, 5'd0, 32'h504, 1'b1));
    idle(1'b1);
    chk("ill_clear", id_illegal, 1'b0);
    chk("ill_clear_valid", id_valid, 1'b0);
`else
    beat(32'h0000_007F, 32'h500, 1'b1, 1'b0, none);
    chk("ill_valid", id_valid, 1'b0);
    chk("ill_ctrl",  id_ctrl, BUBBLE);
    beat(32'h0050_0090, 32'h504, 1'b1, 1'b0, none);
    chk("ill_lowbits_valid", id_valid, 1'b0);
    idle(1'b1);
`endif

    // Every queued expectation must have been seen
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain: got %0d pending want 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
